// File: rtl/id_ex_pipe_pkg.sv
// Shared field widths and packed-payload layout for the ID/EX pipeline register.
// Layout, LSB first: control bits, ALUOp, opcode, rd, rd1, rd2, imm, pc.
package id_ex_pipe_pkg;

  localparam int ALUOP_W  = 2;
  localparam int OPCODE_W = 11;
  localparam int CTRL_W   = 6;

  localparam int CTRL_LSB   = 0;
  localparam int ALUOP_LSB  = CTRL_LSB + CTRL_W;
  localparam int OPCODE_LSB = ALUOP_LSB + ALUOP_W;
  localparam int RD_LSB     = OPCODE_LSB + OPCODE_W;

  typedef struct packed {
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ctrl_t;

  function automatic int rd1_lsb(input int reg_w);
    return RD_LSB + reg_w;
  endfunction

  function automatic int rd2_lsb(input int data_w, input int reg_w);
    return rd1_lsb(reg_w) + data_w;
  endfunction

  function automatic int imm_lsb(input int data_w, input int reg_w);
    return rd1_lsb(reg_w) + 2 * data_w;
  endfunction

  function automatic int pc_lsb(input int data_w, input int reg_w);
    return rd1_lsb(reg_w) + 3 * data_w;
  endfunction

  function automatic int payload_w(input int data_w, input int reg_w);
    return rd1_lsb(reg_w) + 4 * data_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_skid_buffer.sv
// One-stage ready/valid register with a single skid entry; in_ready is a flop
// so upstream never sees a combinational path from out_ready.
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_xfer;
  logic             main_load;

  assign in_xfer   = in_valid && in_ready_q;
  assign main_load = !out_valid_q || out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // payload registers keep their contents; only the valids are squashed
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d      = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register: packs decoded fields into one vector,
// carries it through a skid buffer, and forces side-effecting controls low on bubbles.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic                in_alusrc,
  input  logic                in_regwrite,
  input  logic                in_memread,
  input  logic                in_memwrite,
  input  logic                in_memtoreg,
  input  logic                in_branch,
  input  logic [DATA_W-1:0]   in_rd1,
  input  logic [DATA_W-1:0]   in_rd2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [REG_W-1:0]    in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic                out_alusrc,
  output logic                out_regwrite,
  output logic                out_memread,
  output logic                out_memwrite,
  output logic                out_memtoreg,
  output logic                out_branch,
  output logic [DATA_W-1:0]   out_rd1,
  output logic [DATA_W-1:0]   out_rd2,
  output logic [DATA_W-1:0]   out_imm,
  output logic [DATA_W-1:0]   out_pc,
  output logic [REG_W-1:0]    out_rd
);

  localparam int P_W     = payload_w(DATA_W, REG_W);
  localparam int RD1_LSB = rd1_lsb(REG_W);
  localparam int RD2_LSB = rd2_lsb(DATA_W, REG_W);
  localparam int IMM_LSB = imm_lsb(DATA_W, REG_W);
  localparam int PC_LSB  = pc_lsb(DATA_W, REG_W);

  ctrl_t          in_ctrl;
  ctrl_t          out_ctrl;
  logic [P_W-1:0] in_pay;
  logic [P_W-1:0] out_pay;
  logic           valid_int;

  assign in_ctrl = {in_alusrc, in_regwrite, in_memread, in_memwrite, in_memtoreg, in_branch};
  assign in_pay  = {in_pc, in_imm, in_rd2, in_rd1, in_rd, in_opcode, in_aluop, in_ctrl};

  pipe_skid_buffer #(
    .WIDTH(P_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pay),
    .out_valid(valid_int),
    .out_ready(out_ready),
    .out_data (out_pay)
  );

  assign out_ctrl   = out_pay[CTRL_LSB +: CTRL_W];
  assign out_aluop  = out_pay[ALUOP_LSB +: ALUOP_W];
  assign out_opcode = out_pay[OPCODE_LSB +: OPCODE_W];
  assign out_rd     = out_pay[RD_LSB +: REG_W];
  assign out_rd1    = out_pay[RD1_LSB +: DATA_W];
  assign out_rd2    = out_pay[RD2_LSB +: DATA_W];
  assign out_imm    = out_pay[IMM_LSB +: DATA_W];
  assign out_pc     = out_pay[PC_LSB +: DATA_W];

  // a bubble must not write registers, touch memory or redirect
  assign out_valid    = valid_int;
  assign out_alusrc   = out_ctrl.alusrc;
  assign out_memtoreg = out_ctrl.memtoreg;
  assign out_regwrite = out_ctrl.regwrite && valid_int;
  assign out_memread  = out_ctrl.memread && valid_int;
  assign out_memwrite = out_ctrl.memwrite && valid_int;
  assign out_branch   = out_ctrl.branch && valid_int;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, async-reset sequence, then
// randomized valid/ready/flush traffic checked against a FIFO scoreboard.
module tb_id_ex_pipe;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_aluop;
  logic [10:0]        in_opcode;
  logic               in_alusrc, in_regwrite, in_memread, in_memwrite, in_memtoreg, in_branch;
  logic [DATA_W-1:0]  in_rd1, in_rd2, in_imm, in_pc;
  logic [REG_W-1:0]   in_rd;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_aluop;
  logic [10:0]        out_opcode;
  logic               out_alusrc, out_regwrite, out_memread, out_memwrite, out_memtoreg, out_branch;
  logic [DATA_W-1:0]  out_rd1, out_rd2, out_imm, out_pc;
  logic [REG_W-1:0]   out_rd;

  id_ex_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_opcode(in_opcode), .in_alusrc(in_alusrc),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg), .in_branch(in_branch),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_opcode(out_opcode), .out_alusrc(out_alusrc),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_branch(out_branch),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  aluop;
    logic [10:0] opcode;
    logic        alusrc, regwrite, memread, memwrite, memtoreg, branch;
    logic [63:0] rd1, rd2, imm, pc;
    logic [4:0]  rd;
  } pay_t;

  typedef struct {
    logic        iv;
    logic        kind;
    logic [7:0]  tag;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [4:0]  rd;
    logic [63:0] rd1;
    logic        rw;
    logic        mw;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  pay_t sb[$];
  pay_t held;
  logic stall_prev;
  logic flush_prev;
  vec_t vt[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pay(input string name, input pay_t act, input pay_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind 0 = ADD, kind 1 = STUR; tag identifies the instruction
  function automatic pay_t mk(input logic kind, input logic [7:0] tag);
    pay_t p;
    p = '0;
    if (!kind) begin
      p.aluop    = 2'b10;
      p.opcode   = 11'b10001011000;
      p.regwrite = 1'b1;
      p.rd1      = 64'd5;
      p.rd2      = 64'd7;
    end else begin
      p.aluop    = 2'b00;
      p.opcode   = 11'b11111000000;
      p.alusrc   = 1'b1;
      p.memwrite = 1'b1;
      p.rd1      = 64'd100 + {56'd0, tag};
      p.rd2      = {56'd0, tag};
      p.imm      = 64'd8;
    end
    p.pc = 64'h1000 + {54'd0, tag, 2'b00};
    p.rd = tag[4:0];
    return p;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    logic [31:0] r;
    r          = $urandom;
    p.aluop    = r[1:0];
    p.opcode   = r[12:2];
    p.alusrc   = r[13];
    p.regwrite = r[14];
    p.memread  = r[15];
    p.memwrite = r[16];
    p.memtoreg = r[17];
    p.branch   = r[18];
    p.rd       = r[23:19];
    p.rd1      = {$urandom, $urandom};
    p.rd2      = {$urandom, $urandom};
    p.imm      = {$urandom, $urandom};
    p.pc       = {$urandom, $urandom};
    return p;
  endfunction

  function automatic vec_t v(input logic iv, input logic kind, input logic [7:0] tag,
                             input logic ordy, input logic fl, input logic ov, input logic ir,
                             input logic [4:0] rd, input logic [63:0] rd1, input logic rw,
                             input logic mw);
    vec_t x;
    x.iv = iv; x.kind = kind; x.tag = tag; x.ordy = ordy; x.fl = fl;
    x.ov = ov; x.ir = ir; x.rd = rd; x.rd1 = rd1; x.rw = rw; x.mw = mw;
    return x;
  endfunction

  task automatic drive(input logic iv, input pay_t p);
    in_valid    = iv;
    in_aluop    = p.aluop;
    in_opcode   = p.opcode;
    in_alusrc   = p.alusrc;
    in_regwrite = p.regwrite;
    in_memread  = p.memread;
    in_memwrite = p.memwrite;
    in_memtoreg = p.memtoreg;
    in_branch   = p.branch;
    in_rd1      = p.rd1;
    in_rd2      = p.rd2;
    in_imm      = p.imm;
    in_pc       = p.pc;
    in_rd       = p.rd;
  endtask

  function automatic pay_t cur_in();
    return {in_aluop, in_opcode, in_alusrc, in_regwrite, in_memread, in_memwrite,
            in_memtoreg, in_branch, in_rd1, in_rd2, in_imm, in_pc, in_rd};
  endfunction

  function automatic pay_t dut_pay();
    return {out_aluop, out_opcode, out_alusrc, out_regwrite, out_memread, out_memwrite,
            out_memtoreg, out_branch, out_rd1, out_rd2, out_imm, out_pc, out_rd};
  endfunction

  // scoreboard and stall-stability monitor, sampling pre-edge values
  always @(posedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
      flush_prev <= 1'b0;
    end else begin
      if (stall_prev && !flush_prev)
        chk_pay("stall_hold", dut_pay(), held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got extra output %h expected none at %0t", dut_pay(), $time);
        end else begin
          chk_pay("sb_data", dut_pay(), sb[0]);
          void'(sb.pop_front());
        end
      end
      if (flush)
        sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(cur_in());
      held       <= dut_pay();
      stall_prev <= out_valid && !out_ready;
      flush_prev <= flush;
    end
  end

  always @(negedge rst_n) sb.delete();

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);

    vt[0]  = v(1, 0, 1,  1, 0, 1, 1, 5'd1,  64'd5,   1, 0);
    vt[1]  = v(1, 0, 2,  1, 0, 1, 1, 5'd2,  64'd5,   1, 0);
    vt[2]  = v(1, 0, 3,  1, 0, 1, 1, 5'd3,  64'd5,   1, 0);
    vt[3]  = v(1, 0, 4,  1, 0, 1, 1, 5'd4,  64'd5,   1, 0);
    vt[4]  = v(0, 0, 0,  1, 0, 0, 1, 5'd4,  64'd5,   0, 0);
    vt[5]  = v(1, 0, 5,  0, 0, 1, 1, 5'd5,  64'd5,   1, 0);
    vt[6]  = v(1, 0, 6,  0, 0, 1, 0, 5'd5,  64'd5,   1, 0);
    vt[7]  = v(1, 0, 7,  0, 0, 1, 0, 5'd5,  64'd5,   1, 0);
    vt[8]  = v(0, 0, 0,  1, 0, 1, 1, 5'd6,  64'd5,   1, 0);
    vt[9]  = v(0, 0, 0,  1, 0, 0, 1, 5'd6,  64'd5,   0, 0);
    vt[10] = v(1, 0, 8,  0, 0, 1, 1, 5'd8,  64'd5,   1, 0);
    vt[11] = v(1, 0, 9,  0, 0, 1, 0, 5'd8,  64'd5,   1, 0);
    vt[12] = v(1, 0, 10, 0, 1, 0, 1, 5'd8,  64'd5,   0, 0);
    vt[13] = v(1, 0, 11, 1, 1, 0, 1, 5'd8,  64'd5,   0, 0);
    vt[14] = v(1, 0, 12, 0, 0, 1, 1, 5'd12, 64'd5,   1, 0);
    vt[15] = v(0, 0, 0,  1, 1, 0, 1, 5'd12, 64'd5,   0, 0);
    vt[16] = v(1, 1, 13, 1, 0, 1, 1, 5'd13, 64'd113, 0, 1);
    vt[17] = v(0, 0, 0,  1, 0, 0, 1, 5'd13, 64'd113, 0, 0);
    vt[18] = v(0, 0, 0,  1, 0, 0, 1, 5'd13, 64'd113, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_aluop",     {62'd0, out_aluop}, 64'd0);
    chk("reset_rd1",       out_rd1,            64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].iv, mk(vt[i].kind, vt[i].tag));
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid},    {63'd0, vt[i].ov});
      chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},     {63'd0, vt[i].ir});
      chk($sformatf("v%0d_out_rd", i),    {59'd0, out_rd},       {59'd0, vt[i].rd});
      chk($sformatf("v%0d_out_rd1", i),   out_rd1,               vt[i].rd1);
      chk($sformatf("v%0d_regwrite", i),  {63'd0, out_regwrite}, {63'd0, vt[i].rw});
      chk($sformatf("v%0d_memwrite", i),  {63'd0, out_memwrite}, {63'd0, vt[i].mw});
    end
    flush = 1'b0;

    // async reset while both entries are occupied
    out_ready = 1'b0;
    drive(1'b1, mk(1'b0, 8'd14));
    @(posedge clk); #1;
    drive(1'b1, mk(1'b0, 8'd15));
    @(posedge clk); #1;
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    chk("full_in_ready",  {63'd0, in_ready},  64'd0);
    drive(1'b0, mk(1'b0, 8'd0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("arst_aluop",     {62'd0, out_aluop}, 64'd0);
    chk("arst_rd",        {59'd0, out_rd},    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, mk(1'b0, 8'd16));
    @(posedge clk); #1;
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_rd",        {59'd0, out_rd},    64'd16);
    chk("post_rst_aluop",     {62'd0, out_aluop}, 64'd2);
    drive(1'b0, mk(1'b0, 8'd0));
    @(posedge clk); #1;

    for (int c = 0; c < 10000; c++) begin
      drive(($urandom % 4) != 0, rnd_pay());
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 64) == 0;
      @(posedge clk);
      #1;
    end

    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, mk(1'b0, 8'd0));
    repeat (5) @(posedge clk);
    #1;
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_sb_empty",  64'(sb.size()),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register for the ARM pipeline; sits directly upstream of ALU control and the ALU.
- Captures decoded control bits, including ALUOp and the 11-bit opcode, plus operands and destination. Presents them to execute one cycle later.
- Uses a ready/valid handshake on both sides with a one-entry skid buffer, so back-pressure from execute never drops or duplicates an instruction.
- A synchronous flush squashes in-flight entries on a branch redirect.

Parameters:
- DATA_W, 64, operand, immediate and PC width.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle; driven from a register.
- in_aluop  in  2  ALUOp from the main control unit.
- in_opcode  in  11  instruction[31:21].
- in_alusrc  in  1  select immediate as the second operand.
- in_regwrite, in_memread, in_memwrite, in_memtoreg, in_branch  in  1 each  control bits.
- in_rd1, in_rd2, in_imm, in_pc  in  DATA_W each  operands, sign-extended immediate, PC.
- in_rd  in  REG_W  destination register.
- out_valid  out  1  execute holds a valid instruction.
- out_ready  in  1  execute consumes this cycle.
- out_*  out  same widths as the matching in_* ports  registered payload.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, skid_valid=0. All out_* payload is 0, so out_aluop=2'b00.
- Handshake: a transfer occurs when valid&&ready on the same rising edge. Throughput is 1/cycle. Latency is 1 cycle from in-transfer to out_valid when execute is not stalled. Order is strictly preserved.
- in_ready equals ~skid_valid, registered. It never depends combinationally on out_ready.
- Main register load rule: load when (!out_valid || out_ready). Source is the skid entry if skid_valid, else the input when an in-transfer occurs.
- If out_valid && out_ready and no new source exists, out_valid goes to 0.
- Skid capture: when out_valid && !out_ready && in-transfer, the payload goes into the skid register, skid_valid goes to 1, and in_ready drops next cycle.
- Skid drain: on the first cycle with out_ready=1, the skid entry moves to main and skid_valid goes to 0. in_ready returns to 1 the following cycle.
- Simultaneous drain and input are impossible, because in_ready=0 while skid_valid=1.
- Bubble masking: when out_valid=0, out_regwrite, out_memread, out_memwrite and out_branch read 0, so a bubble is architecturally a NOP. Other payload holds its last value.
- Flush (synchronous, highest priority): out_valid=0 and skid_valid=0 next edge, in_ready=1 next cycle.
  - An in-transfer in the flush cycle is discarded.
  - An out-transfer in the flush cycle still counts as consumed.
- Stall hold: while out_valid && !out_ready, all out_* are stable (no glitch, no change).
- Reset mid-operation: both entries are dropped immediately, with no partial payload visible after release.

Decomposition:
- Shared definitions header: payload field widths, packed-payload bit offsets (ALUOp, opcode, control bits, operands), and total PAYLOAD_W.
- Sub-module pipe_skid_buffer, parameterized by WIDTH. It implements main and skid registers, the valid/ready logic and flush on an opaque vector.
- id_ex_pipe packs and unpacks fields and applies bubble masking to the control outputs.

Test Plan:
- Stream, out_ready=1: 4 back-to-back ADD instructions (opcode 11'b10001011000, ALUOp 2'b10, rd1=5, rd2=7) -> each appears on out_* exactly 1 cycle later, out_valid continuous, in_ready stays 1.
- Back-pressure: out_ready=0 for 3 cycles while A then B are offered -> A held on out_*, B captured in skid, in_ready=0 from the cycle after B. With out_ready=1: A then B delivered in order, in_ready=1 one cycle after B moves to main.
- Flush with skid full and in_valid=1 carrying C -> next cycle out_valid=0, in_ready=1, C never appears, out_regwrite=0 and out_memwrite=0.
- Bubble: in_valid=0 for 2 cycles after a STUR (memwrite=1) drains -> out_valid=0 and out_memwrite=0, while out_rd1 keeps its last value.
- Async reset asserted mid-stall with both entries full -> out_valid=0, out_aluop=2'b00, in_ready=1 immediately, before any clock edge. After release, the first new instruction passes with 1-cycle latency.
- Randomized valid/ready with a scoreboard, 10k cycles -> no loss, duplication or reordering, and stable outputs whenever out_valid && !out_ready.
